shreg_sched: RTL

SHREG_SCHED -- requirements
Module: shreg_sched

---
 rtl/shreg_sched_if.sv | 28 ++
 rtl/shreg_sched.sv | 109 ++++++++++
 2 files changed

// File: rtl/shreg_sched_if.sv
// Request/grant and shift-register bus between two requesters and shreg_sched.
// Requesters drive through master; the scheduler sits on slave.
interface shreg_sched_if #(
  parameter int unsigned WIDTH = 3
);
  logic             req0;
  logic [WIDTH-1:0] data0;
  logic             req1;
  logic [WIDTH-1:0] data1;
  logic             gnt0;
  logic             gnt1;
  logic             sr_clr;
  logic             sr_en;
  logic             sr_d;
  logic             busy;
  logic             done;
  logic             done_id;

  modport master (
    output req0, data0, req1, data1,
    input  gnt0, gnt1, sr_clr, sr_en, sr_d, busy, done, done_id
  );

  modport slave (
    input  req0, data0, req1, data1,
    output gnt0, gnt1, sr_clr, sr_en, sr_d, busy, done, done_id
  );
endinterface

// File: rtl/shreg_sched.sv
// Round-robin two-requester scheduler that clears a serial shift register and
// then shifts the granted word into it MSB first.
module shreg_sched #(
  parameter int unsigned WIDTH = 3
) (
  input  logic         clk,
  input  logic         rst,
  shreg_sched_if.slave bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    count, count_n;
  logic [WIDTH-1:0] word, word_n;
  logic             winner, winner_n;
  logic             ptr, ptr_n;
  logic             win;
  logic [CW-1:0]    idx;

  logic gnt0_q, gnt1_q, sr_clr_q, sr_en_q, sr_d_q, busy_q, done_q, done_id_q;
  logic gnt0_n, gnt1_n, sr_clr_n, sr_en_n, sr_d_n, busy_n, done_n, done_id_n;

  // State register; outputs are registered copies of what the next state decodes to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      word      <= '0;
      winner    <= 1'b0;
      ptr       <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      sr_clr_q  <= 1'b0;
      sr_en_q   <= 1'b0;
      sr_d_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      word      <= word_n;
      winner    <= winner_n;
      ptr       <= ptr_n;
      gnt0_q    <= gnt0_n;
      gnt1_q    <= gnt1_n;
      sr_clr_q  <= sr_clr_n;
      sr_en_q   <= sr_en_n;
      sr_d_q    <= sr_d_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      done_id_q <= done_id_n;
    end
  end

  // Next-state, arbitration and next-output decode.
  always_comb begin
    state_n  = state;
    count_n  = count;
    word_n   = word;
    winner_n = winner;
    ptr_n    = ptr;
    win      = 1'b0;

    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // Pointer only matters on a tie; a lone requester always wins.
          win      = (bus.req0 && bus.req1) ? ptr : bus.req1;
          state_n  = CLEAR;
          word_n   = win ? bus.data1 : bus.data0;
          winner_n = win;
          ptr_n    = ~win;
        end
      end
      CLEAR: begin
        state_n = SHIFT;
        count_n = '0;
      end
      SHIFT: begin
        if (count == CW'(WIDTH - 1)) state_n = DONE;
        else                         count_n = count + CW'(1);
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    idx       = CW'(WIDTH - 1) - count_n;
    gnt0_n    = (state_n == CLEAR) && !winner_n;
    gnt1_n    = (state_n == CLEAR) &&  winner_n;
    sr_clr_n  = (state_n == CLEAR);
    sr_en_n   = (state_n == SHIFT);
    sr_d_n    = (state_n == SHIFT) ? word_n[idx] : 1'b0;
    busy_n    = (state_n != IDLE);
    done_n    = (state_n == DONE);
    done_id_n = (state_n == DONE) ? winner_n : 1'b0;
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.sr_clr  = sr_clr_q;
  assign bus.sr_en   = sr_en_q;
  assign bus.sr_d    = sr_d_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
endmodule
